// File: rtl/fb_branch_predict_table.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the Firebird front end.
// Lookup is combinational; training and the branch/mispredict counters update on the clock edge.
module fb_branch_predict_table #(
    parameter  int IDX_W = 4,
    localparam int TAG_W = 32 - IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lk_pc,
    output logic        lk_hit,
    output logic        lk_taken,
    output logic [31:0] lk_next_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic [31:0] upd_pred_next_pc,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mp_cnt
);
    localparam int DEPTH = 2 ** IDX_W;

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][TAG_W-1:0]  tag_q;
    logic [DEPTH-1:0][31:0]       tgt_q;
    logic [DEPTH-1:0][1:0]        ctr_q;
    logic [31:0]                  br_cnt_q, br_cnt_d;
    logic [31:0]                  mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             upd_hit;
    logic             ent_we;
    logic [TAG_W-1:0] ent_tag_d;
    logic [31:0]      ent_tgt_d;
    logic [1:0]       ent_ctr_d;
    logic [31:0]      actual_next;

    assign lk_idx  = lk_pc[IDX_W-1:0];
    assign lk_tag  = lk_pc[31:IDX_W];
    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_tag = upd_pc[31:IDX_W];

    // Lookup reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit     = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken   = lk_hit && ctr_q[lk_idx][1];
        lk_next_pc = lk_taken ? tgt_q[lk_idx] : lk_pc + 32'd1;
    end

    always_comb begin
        actual_next = upd_taken ? upd_target : upd_pc + 32'd1;
        mispredict  = upd_valid && (actual_next != upd_pred_next_pc);
        redirect_pc = upd_valid ? actual_next : 32'd0;
    end

    always_comb begin
        upd_hit   = vld_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ent_we    = 1'b0;
        ent_tag_d = tag_q[upd_idx];
        ent_tgt_d = tgt_q[upd_idx];
        ent_ctr_d = ctr_q[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                ent_we = 1'b1;
                if (upd_taken) begin
                    ent_tgt_d = upd_target;
                    if (ctr_q[upd_idx] != 2'b11) ent_ctr_d = ctr_q[upd_idx] + 2'd1;
                end else begin
                    if (ctr_q[upd_idx] != 2'b00) ent_ctr_d = ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever occupant aliases onto this index.
                ent_we    = 1'b1;
                ent_tag_d = upd_tag;
                ent_tgt_d = upd_target;
                ent_ctr_d = 2'b10;
            end
        end
    end

    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd_valid && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
        if (mispredict && (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_d = mp_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= '0;
            tag_q    <= '0;
            tgt_q    <= '0;
            ctr_q    <= '0;
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (ent_we) begin
                vld_q[upd_idx] <= 1'b1;
                tag_q[upd_idx] <= ent_tag_d;
                tgt_q[upd_idx] <= ent_tgt_d;
                ctr_q[upd_idx] <= ent_ctr_d;
            end
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_cnt = br_cnt_q;
    assign mp_cnt = mp_cnt_q;

endmodule

// File: tb/tb_fb_branch_predict_table.sv
// Directed and random stimulus for fb_branch_predict_table against a table-of-entries reference model.
module tb_fb_branch_predict_table;
    localparam int          DEPTH = 16;
    localparam logic [31:0] SAT   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lk_pc;
    logic        lk_hit, lk_taken;
    logic [31:0] lk_next_pc;
    logic        upd_valid;
    logic [31:0] upd_pc, upd_target, upd_pred_next_pc;
    logic        upd_taken;
    logic        mispredict;
    logic [31:0] redirect_pc, br_cnt, mp_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: one record per table slot plus plain integer counters.
    bit          m_v   [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];
    logic [31:0] m_br, m_mp;

    fb_branch_predict_table #(.IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken), .lk_next_pc(lk_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_next_pc(upd_pred_next_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[pc % DEPTH] && (m_tag[pc % DEPTH] == pc / DEPTH);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        if (m_hit(pc) && m_ctr[pc % DEPTH] >= 2) return m_tgt[pc % DEPTH];
        return pc + 32'd1;
    endfunction

    // One cycle: drive, check combinational outputs against pre-edge model, clock, train model, check counters.
    task automatic step(input bit uv, input logic [31:0] upc, input bit utk,
                        input logic [31:0] utgt, input logic [31:0] upred,
                        input logic [31:0] lpc, input bit do_rst);
        logic [31:0] actual;
        bit          exp_mp;
        int          idx;
        @(negedge clk);
        rst_n = !do_rst;
        upd_valid = uv; upd_pc = upc; upd_taken = utk;
        upd_target = utgt; upd_pred_next_pc = upred; lk_pc = lpc;
        #1;
        chk("lk_hit", {31'd0, lk_hit}, {31'd0, m_hit(lpc)});
        chk("lk_taken", {31'd0, lk_taken}, {31'd0, m_hit(lpc) && m_ctr[lpc % DEPTH] >= 2});
        chk("lk_next_pc", lk_next_pc, m_next(lpc));
        actual = utk ? utgt : upc + 32'd1;
        exp_mp = uv && (actual != upred);
        chk("mispredict", {31'd0, mispredict}, {31'd0, exp_mp});
        chk("redirect_pc", redirect_pc, uv ? actual : 32'd0);
        @(posedge clk);
        if (do_rst) m_clear();
        else if (uv) begin
            if (m_br != SAT) m_br++;
            if (exp_mp && m_mp != SAT) m_mp++;
            idx = upc % DEPTH;
            if (m_hit(upc)) begin
                if (utk) begin
                    m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    m_tgt[idx] = utgt;
                end else
                    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end else if (utk) begin
                m_v[idx] = 1; m_tag[idx] = upc / DEPTH; m_tgt[idx] = utgt; m_ctr[idx] = 2;
            end
        end
        #1;
        chk("br_cnt", br_cnt, m_br);
        chk("mp_cnt", mp_cnt, m_mp);
    endtask

    task automatic look(input logic [31:0] lpc);
        step(0, 32'd0, 0, 32'd0, 32'd0, lpc, 0);
    endtask

    initial begin
        logic [31:0] pc, tgt, pred;
        bit          tk;
        rst_n = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_next_pc = 0; lk_pc = 0;
        m_clear();
        repeat (2) @(posedge clk);

        look(32'h40);
        step(1, 32'h40, 1, 32'h20, 32'h41, 32'h40, 0);   // allocate; same-cycle lookup misses
        look(32'h40);
        repeat (3) step(1, 32'h40, 1, 32'h20, 32'h20, 32'h40, 0);
        repeat (2) step(1, 32'h40, 0, 32'h0, 32'h20, 32'h40, 0);
        look(32'h40);
        step(1, 32'h50, 1, 32'h99, 32'h51, 32'h40, 0);   // alias onto index 0
        look(32'h40);
        look(32'h50);
        step(1, 32'h60, 1, 32'h123, 32'h61, 32'h60, 0);
        look(32'h60);
        step(1, SAT, 0, 32'h0, 32'h0, SAT, 0);            // pc+1 wraps to 0
        look(SAT);

        @(negedge clk);
        force dut.br_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        m_br = 32'hFFFF_FFFE;
        chk("br_cnt_preload", br_cnt, m_br);
        repeat (3) step(1, 32'h40, 1, 32'h99, 32'h41, 32'h40, 0);
        step(1, 32'h70, 1, 32'h5, 32'h0, 32'h70, 1);     // reset beats the update
        look(32'h70);
        look(32'h50);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0)
                pc = $urandom;
            else
                pc = {$urandom_range(0, 2), 4'(($urandom_range(0, 15)))};
            tk  = $urandom_range(0, 1);
            tgt = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0: pred = m_next(pc);
                1: pred = pc + 32'd1;
                default: pred = tgt;
            endcase
            step($urandom_range(0, 4) != 0, pc, tk, tgt, pred,
                 $urandom_range(0, 1) ? pc : {$urandom_range(0, 2), 4'(($urandom_range(0, 15)))},
                 $urandom_range(0, 59) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fb_branch_predict_table.md
Name: fb_branch_predict_table

Overview:
- Dynamic branch predictor for the Firebird pipeline; the resolution/feedback end of the branch-prediction path.
- IF stage looks up the fetch pc and receives a predicted next pc.
- EX/MEM stage returns each resolved branch/jump outcome. The block trains a direct-mapped BTB with 2-bit saturating counters and flags mispredicts with a redirect pc.
- pc is word-addressed: sequential next pc = pc + 1.

Parameters:
IDX_W, 4, index width; table depth = 2**IDX_W entries
TAG_W, 32-IDX_W, tag width (derived, not overridable)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
lk_pc  in  32  IF-stage fetch pc
lk_hit  out  1  valid entry with matching tag
lk_taken  out  1  predicted taken (hit and counter[1]==1)
lk_next_pc  out  32  lk_taken ? stored target : lk_pc+1
upd_valid  in  1  resolved control-transfer instruction present this cycle
upd_pc  in  32  pc of resolved instruction
upd_taken  in  1  actual direction (jal/jalr always 1)
upd_target  in  32  actual taken target
upd_pred_next_pc  in  32  next pc the front end actually fetched after this instruction
mispredict  out  1  resolved next pc differs from upd_pred_next_pc
redirect_pc  out  32  correct next pc
br_cnt  out  32  resolved control transfers counted
mp_cnt  out  32  mispredicts counted

Behaviour:
- Index = pc[IDX_W-1:0]; tag = pc[31:IDX_W]. Each entry holds valid(1), tag, target(32), ctr(2).
- Lookup:
  - Purely combinational from lk_pc and the current table state.
  - lk_hit = valid & tag match.
  - Miss gives lk_taken=0 and lk_next_pc=lk_pc+1.
- Resolve:
  - actual_next = upd_taken ? upd_target : upd_pc+1, computed combinationally.
  - mispredict = upd_valid & (actual_next != upd_pred_next_pc).
  - redirect_pc = actual_next whenever upd_valid, else 0. It is driven in the same cycle; the downstream hazard logic flushes on mispredict.
- Table update at the clk edge when upd_valid=1:
  - Hit, taken: ctr = min(ctr+1,3); target <= upd_target.
  - Hit, not taken: ctr = max(ctr-1,0); target unchanged.
  - Miss, taken: allocate (overwrite any occupant). valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Counters:
  - br_cnt increments on every upd_valid.
  - mp_cnt increments on every mispredict.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- Read/write collision: lookup and update to the same index in the same cycle. Lookup returns the pre-update entry; the new value is visible from the next cycle. No bypass.
- upd_valid=0: table, counters and mispredict are unaffected; mispredict=0.
- Arithmetic:
  - pc+1 is modulo 2**32; 32'hFFFF_FFFF+1 = 0.
  - Stored target is kept as given; no alignment masking, because the producer already masks jalr.
- Reset:
  - Applies when rst_n=0 at a clk edge and overrides a simultaneous update.
  - Clears all valid bits, ctr to 2'b00, targets to 0, br_cnt=mp_cnt=0.
  - Combinational outputs then reflect the empty table: lk_hit=0, lk_taken=0, lk_next_pc=lk_pc+1.
  - Reset mid-training discards all learned state.
- Latency: lookup 0 cycles; training visible 1 cycle after the update edge; mispredict 0 cycles.

Test Plan:
- Reset, then lk_pc=0x40 -> lk_hit=0, lk_next_pc=0x41; br_cnt=mp_cnt=0.
- Update pc=0x40, taken, target=0x20, pred_next=0x41 -> mispredict=1, redirect_pc=0x20, mp_cnt=1. Next cycle, lookup 0x40 -> hit, taken, next=0x20, ctr=2.
- Three more taken updates at 0x40 -> ctr saturates at 3. Then two not-taken updates (pred_next=0x20) -> mispredict=1 each, redirect=0x41, ctr=1. Lookup -> hit, lk_taken=0, next=0x41.
- Aliasing: with 0x40 trained (IDX_W=4), a taken update at pc=0x50, target=0x99 -> entry replaced. Lookup 0x40 -> miss; lookup 0x50 -> next=0x99.
- Same-cycle lookup 0x60 with a first allocating update at 0x60 -> lookup shows miss that cycle, hit the following cycle.
- Force br_cnt to near saturation (preload via long run or hierarchical force to 0xFFFF_FFFE), then 3 updates -> holds 0xFFFF_FFFF. Assert rst_n=0 concurrent with upd_valid -> counters 0, no allocation.
